muntjac_operand_fetch: RTL

//   Operand-fetch stage between decode and execute. Drives the register file's two read ports and interlocks on

---
 rtl/muntjac_pkg.sv | 25 ++
 rtl/muntjac_scoreboard.sv | 61 ++++++
 rtl/muntjac_operand_fetch.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/muntjac_pkg.sv
// Shared types for the muntjac operand-fetch slice: register index, decode request bundle
// and a one-hot decoder that never selects x0.
package muntjac_pkg;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        reg_idx_t rs1;
        reg_idx_t rs2;
        logic     use_rs1;
        logic     use_rs2;
        reg_idx_t rd;
        logic     writes_rd;
    } op_fetch_req_t;

    function automatic logic [31:0] idx_onehot(input reg_idx_t idx, input logic en);
        idx_onehot = '0;
        if (en && idx != REG_ZERO) begin
            idx_onehot[idx] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/muntjac_scoreboard.sv
// Per-register busy scoreboard (x1..x31) with set, writeback clear, flush clear and hazard queries.
// MUNTJAC_OPFETCH_BYPASS_EN selects whether RAW queries see a same-cycle writeback clear.
module muntjac_scoreboard
    import muntjac_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       set_i,
    input  logic [4:0] set_idx_i,
    input  logic       clr_i,
    input  logic [4:0] clr_idx_i,
    input  logic       flush_clr_i,
    input  logic [4:0] flush_idx_i,
    input  logic [4:0] raw_a_idx_i,
    output logic       raw_a_busy_o,
    input  logic [4:0] raw_b_idx_i,
    output logic       raw_b_busy_o,
    input  logic [4:0] waw_idx_i,
    output logic       waw_busy_o
);

    logic [31:1] busy_q;
    logic [31:1] busy_d;
    logic [31:0] busy;
    logic [31:0] busy_eff;
    logic [31:0] set_vec;
    logic [31:0] clr_vec;
    logic [31:0] fclr_vec;
    logic [31:0] next_vec;

    assign busy     = {busy_q, 1'b0};
    assign set_vec  = idx_onehot(set_idx_i, set_i);
    assign clr_vec  = idx_onehot(clr_idx_i, clr_i);
    assign fclr_vec = idx_onehot(flush_idx_i, flush_clr_i);
    assign busy_eff = busy & ~clr_vec;

    // Set is applied last so a new writer wins over a retiring one on the same index.
    assign next_vec = (busy_eff & ~fclr_vec) | set_vec;
    assign busy_d   = next_vec[31:1];

`ifdef MUNTJAC_OPFETCH_BYPASS_EN
    assign raw_a_busy_o = busy_eff[raw_a_idx_i];
    assign raw_b_busy_o = busy_eff[raw_b_idx_i];
`else
    assign raw_a_busy_o = busy[raw_a_idx_i];
    assign raw_b_busy_o = busy[raw_b_idx_i];
`endif
    assign waw_busy_o = busy_eff[waw_idx_i];

    logic unused_bit0;
    assign unused_bit0 = next_vec[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/muntjac_operand_fetch.sv
// Operand-fetch stage: register file reads, busy-scoreboard interlock and a one-entry output register.
// MUNTJAC_OPFETCH_BYPASS_EN enables same-cycle writeback forwarding into the operands.
module muntjac_operand_fetch
    import muntjac_pkg::*;
#(
    parameter int DataWidth    = 64,
    parameter int PayloadWidth = 128
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    de_valid_i,
    output logic                    de_ready_o,
    input  logic [4:0]              de_rs1_i,
    input  logic [4:0]              de_rs2_i,
    input  logic                    de_use_rs1_i,
    input  logic                    de_use_rs2_i,
    input  logic [4:0]              de_rd_i,
    input  logic                    de_writes_rd_i,
    input  logic [PayloadWidth-1:0] de_payload_i,
    output logic [4:0]              rf_raddr_a_o,
    input  logic [DataWidth-1:0]    rf_rdata_a_i,
    output logic [4:0]              rf_raddr_b_o,
    input  logic [DataWidth-1:0]    rf_rdata_b_i,
    input  logic                    wb_valid_i,
    input  logic                    wb_we_i,
    input  logic [4:0]              wb_rd_i,
    input  logic [DataWidth-1:0]    wb_data_i,
    output logic                    ex_valid_o,
    input  logic                    ex_ready_i,
    output logic [DataWidth-1:0]    ex_rs1_data_o,
    output logic [DataWidth-1:0]    ex_rs2_data_o,
    output logic [4:0]              ex_rd_o,
    output logic                    ex_writes_rd_o,
    output logic [PayloadWidth-1:0] ex_payload_o,
    input  logic                    flush_i
);

    op_fetch_req_t req;
    assign req = '{rs1: de_rs1_i, rs2: de_rs2_i, use_rs1: de_use_rs1_i, use_rs2: de_use_rs2_i,
                   rd: de_rd_i, writes_rd: de_writes_rd_i};

    logic                    ex_valid_q, ex_valid_d;
    logic [DataWidth-1:0]    ex_rs1_q, ex_rs1_d;
    logic [DataWidth-1:0]    ex_rs2_q, ex_rs2_d;
    logic [4:0]              ex_rd_q, ex_rd_d;
    logic                    ex_writes_rd_q, ex_writes_rd_d;
    logic [PayloadWidth-1:0] ex_payload_q, ex_payload_d;

    logic raw_a_busy, raw_b_busy, waw_busy;
    logic hazard, slot_free, accept, flush_clr;

    assign rf_raddr_a_o = req.rs1;
    assign rf_raddr_b_o = req.rs2;

    // A flushed writer never reaches writeback, so its busy bit must be released here;
    // one consumed in the same cycle still retires through wb_valid_i.
    assign flush_clr = flush_i && ex_valid_q && ex_writes_rd_q && !ex_ready_i;

    muntjac_scoreboard u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .set_i        (accept && req.writes_rd),
        .set_idx_i    (req.rd),
        .clr_i        (wb_valid_i),
        .clr_idx_i    (wb_rd_i),
        .flush_clr_i  (flush_clr),
        .flush_idx_i  (ex_rd_q),
        .raw_a_idx_i  (req.rs1),
        .raw_a_busy_o (raw_a_busy),
        .raw_b_idx_i  (req.rs2),
        .raw_b_busy_o (raw_b_busy),
        .waw_idx_i    (req.rd),
        .waw_busy_o   (waw_busy)
    );

    assign hazard = (req.use_rs1 && req.rs1 != REG_ZERO && raw_a_busy) ||
                    (req.use_rs2 && req.rs2 != REG_ZERO && raw_b_busy) ||
                    (req.writes_rd && req.rd != REG_ZERO && waw_busy);

    assign slot_free  = !ex_valid_q || ex_ready_i;
    assign de_ready_o = slot_free && !hazard && !flush_i;
    assign accept     = de_valid_i && de_ready_o;

    logic [DataWidth-1:0] op_a, op_b;

`ifdef MUNTJAC_OPFETCH_BYPASS_EN
    logic wb_fwd;
    assign wb_fwd = wb_valid_i && wb_we_i;

    always_comb begin
        op_a = rf_rdata_a_i;
        op_b = rf_rdata_b_i;
        if (req.rs1 == REG_ZERO) begin
            op_a = '0;
        end else if (wb_fwd && wb_rd_i == req.rs1) begin
            op_a = wb_data_i;
        end
        if (req.rs2 == REG_ZERO) begin
            op_b = '0;
        end else if (wb_fwd && wb_rd_i == req.rs2) begin
            op_b = wb_data_i;
        end
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_we_i, wb_data_i};

    always_comb begin
        op_a = (req.rs1 == REG_ZERO) ? '0 : rf_rdata_a_i;
        op_b = (req.rs2 == REG_ZERO) ? '0 : rf_rdata_b_i;
    end
`endif

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_rs1_d       = ex_rs1_q;
        ex_rs2_d       = ex_rs2_q;
        ex_rd_d        = ex_rd_q;
        ex_writes_rd_d = ex_writes_rd_q;
        ex_payload_d   = ex_payload_q;
        if (flush_i) begin
            ex_valid_d = 1'b0;
        end else if (accept) begin
            ex_valid_d     = 1'b1;
            ex_rs1_d       = op_a;
            ex_rs2_d       = op_b;
            ex_rd_d        = req.rd;
            ex_writes_rd_d = req.writes_rd;
            ex_payload_d   = de_payload_i;
        end else if (ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_valid_q     <= 1'b0;
            ex_rs1_q       <= '0;
            ex_rs2_q       <= '0;
            ex_rd_q        <= '0;
            ex_writes_rd_q <= 1'b0;
            ex_payload_q   <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_rs1_q       <= ex_rs1_d;
            ex_rs2_q       <= ex_rs2_d;
            ex_rd_q        <= ex_rd_d;
            ex_writes_rd_q <= ex_writes_rd_d;
            ex_payload_q   <= ex_payload_d;
        end
    end

    assign ex_valid_o     = ex_valid_q;
    assign ex_rs1_data_o  = ex_rs1_q;
    assign ex_rs2_data_o  = ex_rs2_q;
    assign ex_rd_o        = ex_rd_q;
    assign ex_writes_rd_o = ex_writes_rd_q;
    assign ex_payload_o   = ex_payload_q;

endmodule
